// File: rtl/cla_seq_pkg.sv
// Shared types and helpers for the sequenced carry-lookahead adder.
package cla_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIB_BITS = 4;

  // Nibble index width; a single-nibble adder still needs a 1-bit index.
  function automatic int k_width(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/cla_seq_adder_cla4_nibble.sv
// 4-bit combinational carry-lookahead slice: all internal carries are
// formed directly from generate/propagate terms, not rippled.
module cla4_nibble
  import cla_seq_pkg::*;
(
  input  logic [NIB_BITS-1:0] a,
  input  logic [NIB_BITS-1:0] b,
  input  logic                cin,
  output logic [NIB_BITS-1:0] sum,
  output logic                cout
);

  logic [NIB_BITS-1:0] p;
  logic [NIB_BITS-1:0] g;
  logic [NIB_BITS:0]   c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum  = p ^ c[NIB_BITS-1:0];
  assign cout = c[NIB_BITS];

endmodule

// File: rtl/cla_seq_adder.sv
// Sequenced WIDTH-bit adder: one 4-bit CLA slice reused over WIDTH/4 cycles,
// carry held in a register between nibbles, valid/ready framed.
// Optional build macro: CLA_SEQ_SUB_EN adds a 'sub' port (a - b).
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NIB = WIDTH / NIB_BITS;
  localparam int KW  = k_width(NIB);
  localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

  // Width must split into whole nibbles.
  if ((WIDTH % NIB_BITS) != 0 || WIDTH < NIB_BITS) begin : g_width_check
    $error("cla_seq_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  state_t state, state_next;

  logic [WIDTH-1:0]    op_a;
  logic [WIDTH-1:0]    op_b;
  logic                carry;
  logic [KW-1:0]       k;
  logic [WIDTH-1:0]    b_eff;
  logic                cin_eff;
  logic [NIB_BITS-1:0] nib_a;
  logic [NIB_BITS-1:0] nib_b;
  logic [NIB_BITS-1:0] nib_sum;
  logic                nib_cout;

  // Subtract is a + ~b + 1, so it reuses the add path with the operand
  // inverted and the carry forced high at accept.
`ifdef CLA_SEQ_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub | cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  assign nib_a = op_a[{k, 2'b00} +: NIB_BITS];
  assign nib_b = op_b[{k, 2'b00} +: NIB_BITS];

  cla4_nibble u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // Handshake outputs decode registered state only.
  assign start_ready = (state == IDLE);
  assign res_valid   = (state == DONE);
  assign busy        = (state != IDLE);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start_valid)  state_next = RUN;
      RUN:     if (k == K_LAST)  state_next = DONE;
      DONE:    if (res_ready)    state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  // Operand capture at accept; operands are only read in RUN so need no reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && start_valid) begin
      op_a <= a;
      op_b <= b_eff;
    end
  end

  // Nibble sequencing: one slice result per RUN cycle, carry chained via register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k     <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_valid) begin
            k     <= '0;
            carry <= cin_eff;
          end
        end
        RUN: begin
          sum[{k, 2'b00} +: NIB_BITS] <= nib_sum;
          carry                       <= nib_cout;
          if (k == K_LAST) begin
            cout <= nib_cout;
            k    <= '0;
          end else begin
            k <= k + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
